nib_stream_checker: RTL and testbench



---
 rtl/nib_stream_checker_if.sv | 28 ++
 rtl/nib_stream_checker.sv | 129 ++++++++++++
 tb/tb_nib_stream_checker.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/nib_stream_checker_if.sv
// Nibble stream bus between a pattern source and the stream checker.
// Handshake: DIN is consumed on every rising edge where DIN_VALID is high;
// there is no backpressure, so the checker is always ready.
// STATE is a debug view of the checker FSM (0 = HUNT, 1 = ACQUIRE, 2 = LOCKED).
interface nib_stream_checker_if #(
  parameter int CW = 16
);
  logic [3:0]    DIN;
  logic          DIN_VALID;
  logic          LOCKED;
  logic          ERR_PULSE;
  logic [CW-1:0] ERR_COUNT;
  logic [CW-1:0] MATCH_COUNT;
  logic [1:0]    PHASE;
  logic [1:0]    STATE;

  // Stream source side.
  modport master (
    output DIN, DIN_VALID,
    input  LOCKED, ERR_PULSE, ERR_COUNT, MATCH_COUNT, PHASE, STATE
  );

  // Checker side.
  modport slave (
    input  DIN, DIN_VALID,
    output LOCKED, ERR_PULSE, ERR_COUNT, MATCH_COUNT, PHASE, STATE
  );
endinterface

// File: rtl/nib_stream_checker.sv
// Receive-side checker for the repeating 16-bit nibble pattern.
// Hunts for the first pattern nibble, acquires alignment over a run of
// correct nibbles, then counts matches and errors while locked. Loses lock
// after a run of consecutive mismatches. All outputs are registered.
module nib_stream_checker #(
  parameter logic [15:0] PATTERN    = 16'hEAC1,
  parameter int          LOCK_COUNT = 8,
  parameter int          LOSS_COUNT = 4,
  parameter int          CW         = 16
) (
  input  logic                 CLK100MHZ,
  input  logic                 RESET,
  nib_stream_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam logic [7:0] LOCK_C = 8'(LOCK_COUNT);
  localparam logic [7:0] LOSS_C = 8'(LOSS_COUNT);

  state_t        r_state;
  logic [1:0]    r_phase;
  logic [7:0]    r_run;
  logic          r_locked;
  logic          r_err_pulse;
  logic [CW-1:0] r_err_count;
  logic [CW-1:0] r_match_count;

  logic [3:0]    w_exp;
  logic [3:0]    w_first;
  logic [7:0]    w_run_inc;
  logic          w_match;
  logic          w_is_first;
  logic          w_err_sat;
  logic          w_match_sat;

  assign w_exp       = PATTERN[{r_phase, 2'b00} +: 4];
  assign w_first     = PATTERN[3:0];
  assign w_run_inc   = r_run + 8'd1;
  assign w_match     = (bus.DIN == w_exp);
  assign w_is_first  = (bus.DIN == w_first);
  assign w_err_sat   = (r_err_count == {CW{1'b1}});
  assign w_match_sat = (r_match_count == {CW{1'b1}});

  // FSM, alignment phase, run counter and saturating statistics.
  always_ff @(posedge CLK100MHZ) begin
    if (RESET) begin
      r_state       <= ST_HUNT;
      r_phase       <= 2'd0;
      r_run         <= 8'd0;
      r_locked      <= 1'b0;
      r_err_pulse   <= 1'b0;
      r_err_count   <= '0;
      r_match_count <= '0;
    end else begin
      r_err_pulse <= 1'b0;
      if (bus.DIN_VALID) begin
        case (r_state)
          ST_HUNT: begin
            if (w_is_first) begin
              r_state <= ST_ACQUIRE;
              r_phase <= 2'd1;
              r_run   <= 8'd1;
            end else begin
              r_phase <= 2'd0;
            end
          end
          ST_ACQUIRE: begin
            if (w_match) begin
              r_phase <= r_phase + 2'd1;
              if (w_run_inc == LOCK_C) begin
                r_state  <= ST_LOCKED;
                r_locked <= 1'b1;
                r_run    <= 8'd0;
              end else begin
                r_run <= w_run_inc;
              end
            end else if (w_is_first) begin
              // A fresh first nibble restarts alignment instead of dropping to HUNT.
              r_phase <= 2'd1;
              r_run   <= 8'd1;
            end else begin
              r_state <= ST_HUNT;
              r_phase <= 2'd0;
              r_run   <= 8'd0;
            end
          end
          ST_LOCKED: begin
            // Phase free-runs so isolated errors do not disturb alignment.
            r_phase <= r_phase + 2'd1;
            if (w_match) begin
              r_run <= 8'd0;
              if (!w_match_sat) r_match_count <= r_match_count + CW'(1);
            end else begin
              r_err_pulse <= 1'b1;
              if (!w_err_sat) r_err_count <= r_err_count + CW'(1);
              if (w_run_inc == LOSS_C) begin
                r_state  <= ST_HUNT;
                r_locked <= 1'b0;
                r_phase  <= 2'd0;
                r_run    <= 8'd0;
              end else begin
                r_run <= w_run_inc;
              end
            end
          end
          default: begin
            r_state  <= ST_HUNT;
            r_locked <= 1'b0;
            r_phase  <= 2'd0;
            r_run    <= 8'd0;
          end
        endcase
      end
    end
  end

  assign bus.LOCKED      = r_locked;
  assign bus.ERR_PULSE   = r_err_pulse;
  assign bus.ERR_COUNT   = r_err_count;
  assign bus.MATCH_COUNT = r_match_count;
  assign bus.PHASE       = r_phase;
  assign bus.STATE       = r_state;

endmodule

// File: tb/tb_nib_stream_checker.sv
// Testbench for nib_stream_checker: a 16-bit-counter instance and a 4-bit
// counter instance share one stimulus stream. A reference model pushes the
// expected outputs for each driven cycle into a queue; they are popped and
// compared one cycle later, after the clock edge.
module tb_nib_stream_checker;

  localparam int W = 38;

  logic       clk;
  logic       rst;
  logic [3:0] din;
  logic       din_valid;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];

  // Reference model state.
  int         m_state;
  int         m_phase;
  int         m_run;
  int         m_err;
  int         m_match;
  logic       m_pulse;
  logic [15:0] pat;

  nib_stream_checker_if #(.CW(16)) bus ();
  nib_stream_checker_if #(.CW(4))  bus_s ();

  assign bus.DIN         = din;
  assign bus.DIN_VALID   = din_valid;
  assign bus_s.DIN       = din;
  assign bus_s.DIN_VALID = din_valid;

  nib_stream_checker #(.PATTERN(16'hEAC1), .LOCK_COUNT(8), .LOSS_COUNT(4), .CW(16)) dut (
    .CLK100MHZ (clk),
    .RESET     (rst),
    .bus       (bus)
  );

  nib_stream_checker #(.PATTERN(16'hEAC1), .LOCK_COUNT(8), .LOSS_COUNT(4), .CW(4)) dut_s (
    .CLK100MHZ (clk),
    .RESET     (rst),
    .bus       (bus_s)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int sat4(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  // Reference model: one driven cycle.
  task automatic model_cycle(input logic [3:0] nib, input logic v, input logic r);
    logic [3:0] e;
    e = pat[4*m_phase +: 4];
    m_pulse = 1'b0;
    if (r) begin
      m_state = 0; m_phase = 0; m_run = 0; m_err = 0; m_match = 0;
    end else if (v) begin
      if (m_state == 0) begin
        if (nib == pat[3:0]) begin m_state = 1; m_phase = 1; m_run = 1; end
        else m_phase = 0;
      end else if (m_state == 1) begin
        if (nib == e) begin
          m_phase = (m_phase + 1) % 4;
          m_run   = m_run + 1;
          if (m_run == 8) begin m_state = 2; m_run = 0; end
        end else if (nib == pat[3:0]) begin
          m_phase = 1; m_run = 1;
        end else begin
          m_state = 0; m_phase = 0; m_run = 0;
        end
      end else begin
        m_phase = (m_phase + 1) % 4;
        if (nib == e) begin
          if (m_match < 65535) m_match = m_match + 1;
          m_run = 0;
        end else begin
          if (m_err < 65535) m_err = m_err + 1;
          m_pulse = 1'b1;
          m_run   = m_run + 1;
          if (m_run == 4) begin m_state = 0; m_phase = 0; m_run = 0; end
        end
      end
    end
  endtask

  // Driver: one clock cycle with scoreboard push and pop/compare.
  task automatic cycle(input logic [3:0] nib, input logic v, input logic r);
    logic [W-1:0] e;
    rst = r; din = nib; din_valid = v;
    model_cycle(nib, v, r);
    exp_q.push_back({(m_state == 2), m_pulse, 2'(m_phase), 16'(m_err), 16'(m_match), 2'(m_state)});
    @(posedge clk);
    #1;
    rst = 1'b0;
    e = exp_q.pop_front();
    check("locked",      32'(bus.LOCKED),      32'(e[37]));
    check("err_pulse",   32'(bus.ERR_PULSE),   32'(e[36]));
    check("phase",       32'(bus.PHASE),       32'(e[35:34]));
    check("err_count",   32'(bus.ERR_COUNT),   32'(e[33:18]));
    check("match_count", 32'(bus.MATCH_COUNT), 32'(e[17:2]));
    check("state",       32'(bus.STATE),       32'(e[1:0]));
    check("s_err",       32'(bus_s.ERR_COUNT),   32'(sat4(int'(e[33:18]))));
    check("s_match",     32'(bus_s.MATCH_COUNT), 32'(sat4(int'(e[17:2]))));
    check("s_locked",    32'(bus_s.LOCKED),      32'(e[37]));
  endtask

  task automatic send(input logic [3:0] nib);
    cycle(nib, 1'b1, 1'b0);
  endtask

  task automatic send_gap(input logic [3:0] nib);
    cycle(nib, 1'b1, 1'b0);
    cycle(4'($urandom_range(0, 15)), 1'b0, 1'b0);
    cycle(4'($urandom_range(0, 15)), 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(4'h1, 1'b1, 1'b1);
  endtask

  // Directed sequence followed by a random stream.
  initial begin
    logic [3:0] seq [4];
    logic [3:0] nib;
    int g;
    seq[0] = 4'h1; seq[1] = 4'hC; seq[2] = 4'hA; seq[3] = 4'hE;
    pat = 16'hEAC1;
    rst = 1'b1; din = 4'h0; din_valid = 1'b0;
    m_state = 0; m_phase = 0; m_run = 0; m_err = 0; m_match = 0; m_pulse = 1'b0;

    // Reset state.
    do_reset();
    check("rst_locked", 32'(bus.LOCKED), 32'd0);
    check("rst_match",  32'(bus.MATCH_COUNT), 32'd0);

    // Clean lock at full rate.
    for (int i = 0; i < 12; i++) begin
      send(seq[i % 4]);
      if (i == 6) check("t1_not_locked_7", 32'(bus.LOCKED), 32'd0);
      if (i == 7) check("t1_locked_8", 32'(bus.LOCKED), 32'd1);
    end
    check("t1_match", 32'(bus.MATCH_COUNT), 32'd4);
    check("t1_err",   32'(bus.ERR_COUNT),   32'd0);
    check("t1_phase", 32'(bus.PHASE),       32'd0);

    // Single error at phase 2.
    send(4'h1);
    send(4'hC);
    check("t3_phase2", 32'(bus.PHASE), 32'd2);
    send(4'h0);
    check("t3_pulse",  32'(bus.ERR_PULSE), 32'd1);
    check("t3_err",    32'(bus.ERR_COUNT), 32'd1);
    check("t3_locked", 32'(bus.LOCKED),    32'd1);
    send(4'hE);
    check("t3_pulse_off", 32'(bus.ERR_PULSE),   32'd0);
    check("t3_match",     32'(bus.MATCH_COUNT), 32'd7);

    // Gapped valid with misaligned start.
    do_reset();
    send_gap(4'hA);
    send_gap(4'hE);
    check("t2_hunt", 32'(bus.STATE), 32'd0);
    for (int i = 0; i < 8; i++) begin
      send_gap(seq[i % 4]);
      if (i == 6) check("t2_not_locked_7", 32'(bus.LOCKED), 32'd0);
    end
    check("t2_locked", 32'(bus.LOCKED), 32'd1);

    // Loss of lock after four zero nibbles, then relock.
    do_reset();
    for (int i = 0; i < 8; i++) send(seq[i % 4]);
    for (int i = 0; i < 4; i++) begin
      send(4'h0);
      if (i == 2) check("t4_still_locked", 32'(bus.LOCKED), 32'd1);
    end
    check("t4_unlocked", 32'(bus.LOCKED),    32'd0);
    check("t4_pulse",    32'(bus.ERR_PULSE), 32'd1);
    check("t4_err",      32'(bus.ERR_COUNT), 32'd4);
    check("t4_phase",    32'(bus.PHASE),     32'd0);
    for (int i = 0; i < 8; i++) send(seq[i % 4]);
    check("t4_relocked", 32'(bus.LOCKED),    32'd1);
    check("t4_err_hold", 32'(bus.ERR_COUNT), 32'd4);

    // Reset mid-lock with a valid nibble in the reset cycle.
    send(4'h1);
    do_reset();
    check("t6_locked", 32'(bus.LOCKED),      32'd0);
    check("t6_err",    32'(bus.ERR_COUNT),   32'd0);
    check("t6_match",  32'(bus.MATCH_COUNT), 32'd0);
    check("t6_phase",  32'(bus.PHASE),       32'd0);
    check("t6_state",  32'(bus.STATE),       32'd0);

    // Random stream with occasional corrupted nibbles and gaps.
    g = 0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        cycle(4'($urandom_range(0, 15)), 1'b0, 1'b0);
      end else begin
        nib = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : seq[g % 4];
        g++;
        send(nib);
      end
    end

    // Saturation of the 4-bit counters.
    do_reset();
    for (int i = 0; i < 28; i++) send(seq[i % 4]);
    check("t5_s_match", 32'(bus_s.MATCH_COUNT), 32'd15);
    check("t5_match",   32'(bus.MATCH_COUNT),   32'd20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
